// File: rtl/multi_timer.sv
// Multi-channel down-counting timer with shared prescaler and IRQ logic.
// Register-mapped config; per-channel periodic or one-shot expiry pulses.
module multi_timer #(
  parameter int NCH = 4,
  parameter int CW  = 16,
  parameter int DW  = 16,
  parameter int AW  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           write,
  input  logic           read,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  wdata,
  output logic [DW-1:0]  rdata,
  output logic [NCH-1:0] tout,
  output logic           irq
);

  logic [CW-1:0] pre_q, pre_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [NCH-1:0] stat_q, stat_d;
  logic [NCH-1:0] en_q, en_d;
  logic [NCH-1:0] start_q, start_d;
  logic [NCH-1:0] mode_q, mode_d;
  logic [NCH-1:0] tsel_q, tsel_d;
  logic [NCH-1:0] tout_q;
  logic           irq_q, irq_d;
  logic [NCH-1:0][CW-1:0] load_q, load_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;

  logic           pre_tick;
  logic           pre_we, stat_we, en_we;
  logic [NCH-1:0] tick, cfg_we, load_we, reload, expire;
  logic [NCH-1:0] w1c;

  assign pre_tick = (pcnt_q == pre_q);
  assign pre_we   = write && (addr == AW'(0));
  assign stat_we  = write && (addr == AW'(1));
  assign en_we    = write && (addr == AW'(2));
  assign w1c      = stat_we ? wdata[NCH-1:0] : '0;

  always_comb begin
    cfg_we  = '0;
    load_we = '0;
    tick    = '0;
    reload  = '0;
    for (int k = 0; k < NCH; k++) begin
      cfg_we[k]  = write && (addr == AW'(4 + 4*k));
      load_we[k] = write && (addr == AW'(5 + 4*k));
      tick[k]    = tsel_q[k] ? pre_tick : 1'b1;
      // CLR or a START rising edge both restart from LOAD
      reload[k]  = cfg_we[k] &&
                   (wdata[7] || (wdata[0] && !start_q[k]));
    end
  end

  always_comb begin
    pre_d  = pre_q;
    pcnt_d = pre_tick ? '0 : pcnt_q + CW'(1);
    if (pre_we) begin
      pre_d  = wdata[CW-1:0];
      pcnt_d = '0;
    end
    en_d    = en_we ? wdata[NCH-1:0] : en_q;
    start_d = start_q;
    mode_d  = mode_q;
    tsel_d  = tsel_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    expire  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (start_q[k] && tick[k] && !reload[k]) begin
        if (cnt_q[k] != '0) begin
          cnt_d[k] = cnt_q[k] - CW'(1);
        end else begin
          expire[k] = 1'b1;
          if (mode_q[k]) start_d[k] = 1'b0;
          else           cnt_d[k]   = load_q[k];
        end
      end
      if (cfg_we[k]) begin
        start_d[k] = wdata[0];
        mode_d[k]  = wdata[1];
        tsel_d[k]  = wdata[2];
      end
      if (reload[k])  cnt_d[k]  = load_q[k];
      if (load_we[k]) load_d[k] = wdata[CW-1:0];
    end
    // a fresh expiry beats a same-cycle clear
    stat_d = (stat_q & ~w1c) | expire;
    irq_d  = |(stat_d & en_d);
  end

  always_comb begin
    rdata = '0;
    if (read) begin
      case (addr)
        AW'(0):  rdata = DW'(pre_q);
        AW'(1):  rdata = DW'(stat_q);
        AW'(2):  rdata = DW'(en_q);
        default: rdata = '0;
      endcase
      for (int k = 0; k < NCH; k++) begin
        if (addr == AW'(4 + 4*k))
          rdata = DW'({tsel_q[k], mode_q[k], start_q[k]});
        if (addr == AW'(5 + 4*k))
          rdata = DW'(load_q[k]);
        if (addr == AW'(6 + 4*k))
          rdata = DW'(cnt_q[k]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= '0;
      pcnt_q  <= '0;
      stat_q  <= '0;
      en_q    <= '0;
      start_q <= '0;
      mode_q  <= '0;
      tsel_q  <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      tout_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      stat_q  <= stat_d;
      en_q    <= en_d;
      start_q <= start_d;
      mode_q  <= mode_d;
      tsel_q  <= tsel_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      tout_q  <= expire;
      irq_q   <= irq_d;
    end
  end

  assign tout = tout_q;
  assign irq  = irq_q;

endmodule

// File: tb/tb_multi_timer.sv
// Directed scoreboard bench for multi_timer.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_multi_timer;

  logic        clk;
  logic        rst_n;
  logic        write;
  logic        read;
  logic [4:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [3:0]  tout;
  logic        irq;

  int n_eval = 0;
  int n_fail = 0;
  logic [31:0] sb[$];

  multi_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .write (write),
    .read  (read),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata),
    .tout  (tout),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_eval++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic expv(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
    sb.push_back(exp);
    check(tag, obs);
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    write = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    write = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp,
                    input string tag);
    sb.push_back(exp);
    read = 1'b1;
    addr = a;
    #1;
    check(tag, 32'(rdata));
    read = 1'b0;
    addr = '0;
  endtask

  task automatic wait_hi(input int ch, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (tout[ch] !== 1'b1 && n < 200);
  endtask

  task automatic count_hi(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tout !== 4'b0000) hits++;
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    write = 1'b0;
    read  = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    expv("rst_tout", 32'(tout), 0);
    expv("rst_irq", 32'(irq), 0);
    rd(5'd0, 0, "rst_rd_pre");
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 32; a++) rd(5'(a), 0, "init_rd");

    // ch0 periodic, LOAD=9
    wr(5'd5, 16'd9);
    wr(5'd4, 16'h0001);
    sb.push_back(10);
    wait_hi(0, n);
    check("ch0_first", 32'(n));
    rd(5'd6, 9, "ch0_cnt_reload");
    @(negedge clk);
    expv("ch0_width", 32'(tout[0]), 0);
    repeat (2) @(negedge clk);
    rd(5'd6, 6, "ch0_cnt_mid");
    sb.push_back(7);
    wait_hi(0, n);
    check("ch0_rest", 32'(n));
    sb.push_back(10);
    wait_hi(0, n);
    check("ch0_period", 32'(n));
    wr(5'd4, 16'h0000);

    // ch1 on prescaled tick
    wr(5'd0, 16'd1);
    wr(5'd9, 16'd4);
    wr(5'd8, 16'h0005);
    sb.push_back(10);
    wait_hi(1, n);
    check("ch1_first", 32'(n));
    sb.push_back(10);
    wait_hi(1, n);
    check("ch1_pre1", 32'(n));
    wr(5'd0, 16'd3);
    wait_hi(1, n);
    expv("ch1_seen", 32'(tout[1]), 1);
    sb.push_back(20);
    wait_hi(1, n);
    check("ch1_pre3_a", 32'(n));
    sb.push_back(20);
    wait_hi(1, n);
    check("ch1_pre3_b", 32'(n));
    wr(5'd8, 16'h0000);

    // ch2 one-shot with interrupt
    wr(5'd1, 16'h000F);
    rd(5'd1, 0, "stat_clr_all");
    wr(5'd2, 16'h0004);
    wr(5'd13, 16'd3);
    wr(5'd12, 16'h0003);
    sb.push_back(4);
    wait_hi(2, n);
    check("ch2_delay", 32'(n));
    expv("ch2_irq", 32'(irq), 1);
    count_hi(20, n);
    expv("ch2_single", 32'(n), 0);
    rd(5'd12, 2, "ch2_cfg");
    rd(5'd1, 4, "ch2_stat");
    rd(5'd14, 0, "ch2_cnt");
    wr(5'd1, 16'h0004);
    expv("ch2_irq_clr", 32'(irq), 0);
    rd(5'd1, 0, "ch2_stat_clr");

    // clear colliding with expiry, then CLR while running
    wr(5'd4, 16'h0001);
    sb.push_back(10);
    wait_hi(0, n);
    check("w1c_first", 32'(n));
    repeat (9) @(negedge clk);
    wr(5'd1, 16'h0001);
    expv("w1c_tout", 32'(tout[0]), 1);
    rd(5'd1, 1, "w1c_set_wins");
    wr(5'd1, 16'h0001);
    rd(5'd1, 0, "w1c_plain");
    repeat (2) @(negedge clk);
    wr(5'd4, 16'h0081);
    rd(5'd6, 9, "clr_cnt");
    rd(5'd4, 1, "clr_cfg");
    sb.push_back(10);
    wait_hi(0, n);
    check("clr_period", 32'(n));

    // all channels running, LOAD=0 on ch3, then reset
    wr(5'd2, 16'h000F);
    wr(5'd9, 16'd4);
    wr(5'd8, 16'h0001);
    wr(5'd13, 16'd3);
    wr(5'd12, 16'h0001);
    wr(5'd17, 16'd0);
    wr(5'd16, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expv("ch3_cont", 32'(tout[3]), 1);
    end
    expv("irq_all", 32'(irq), 1);
    rst_n = 1'b0;
    @(negedge clk);
    expv("rst2_tout", 32'(tout), 0);
    expv("rst2_irq", 32'(irq), 0);
    for (int a = 0; a < 32; a++) rd(5'(a), 0, "rst2_rd");
    rst_n = 1'b1;
    count_hi(30, n);
    expv("rst2_quiet", 32'(n), 0);
    expv("rst2_irq_after", 32'(irq), 0);
    rd(5'd6, 0, "rst2_cnt0");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_eval, n_fail);
    $finish;
  end

endmodule
